// File: rtl/avalon_io_responder_pkg.sv
// Shared word indices, status bit positions and the read-response record for
// the Avalon I/O responder.
package avalon_io_pkg;

  localparam logic [5:0] CTRL_WORD   = 6'd0;
  localparam logic [5:0] STATUS_WORD = 6'd1;

  localparam int ERR_BIT   = 0;
  localparam int WRCNT_LSB = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        eop;
    logic        valid;
  } rsp_t;

  typedef enum logic {
    IDLE,
    ACK
  } ws_state_e;

endpackage

// File: rtl/avalon_io_responder_if.sv
// Avalon-MM command/response bundle between the bridge master port and the
// responder.
interface avalon_io_responder_if;

  logic [7:0]  address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        endofpacket;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid, endofpacket
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid, endofpacket
  );

endinterface

// File: rtl/avalon_io_responder_rd_pipe.sv
// Fixed-latency read response pipeline; data/eop only load on a valid entry so
// the output holds the last response while no new one is presented.
module avalon_io_rd_pipe
  import avalon_io_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  rsp_t rsp_i,
  output rsp_t rsp_o
);

  rsp_t stage_d [LATENCY];
  rsp_t stage_q [LATENCY];

  always_comb begin
    stage_d[0] = rsp_i;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i].valid <= stage_d[i].valid;
        if (stage_d[i].valid) begin
          stage_q[i].data <= stage_d[i].data;
          stage_q[i].eop  <= stage_d[i].eop;
        end
      end
    end
  end

  assign rsp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/avalon_io_responder.sv
// Avalon-MM register-bank responder on the bridge master clock.
// Optional wait-state handshake: define AVALON_IO_RESPONDER_WAIT_STATE_EN.
module avalon_io_responder
  import avalon_io_pkg::*;
#(
  parameter int          NUM_WORDS    = 48,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] OOR_DATA     = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_io_responder_if.slave  avs,
  output logic [31:0]           ctrl_out
);

  logic [5:0]  word;
  logic        cmd, accept, wr_acc, rd_acc, in_range;
  logic        bank_we, err_set, err_clr;
  logic        waitrequest;
  logic [31:0] bank_q [NUM_WORDS];
  logic [31:0] wdata_d, status;
  logic        err_q, err_d;
  logic [7:0]  wrcnt_q, wrcnt_d;
  rsp_t        rsp_d, rsp_q;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^avs.address[1:0];
  assign word     = avs.address[7:2];
  assign in_range = (int'(word) < NUM_WORDS);
  assign cmd      = avs.read | avs.write;
  assign accept   = cmd & ~waitrequest;
  // A simultaneous read+write performs the write and drops the read.
  assign wr_acc   = accept & avs.write;
  assign rd_acc   = accept & avs.read & ~avs.write;
  assign bank_we  = wr_acc & in_range & (word != STATUS_WORD);
  assign err_set  = accept & ~in_range;
  assign err_clr  = rd_acc & (word == STATUS_WORD);

  always_comb begin
    wdata_d = in_range ? bank_q[word] : '0;
    for (int b = 0; b < 4; b++) begin
      if (avs.byteenable[b]) wdata_d[8*b +: 8] = avs.writedata[8*b +: 8];
    end
    status                   = '0;
    status[ERR_BIT]          = err_q;
    status[WRCNT_LSB +: 8]   = wrcnt_q;
    rsp_d.valid = rd_acc;
    rsp_d.eop   = in_range & (word == 6'(NUM_WORDS - 1));
    if (!in_range)                rsp_d.data = OOR_DATA;
    else if (word == STATUS_WORD) rsp_d.data = status;
    else                          rsp_d.data = bank_q[word];
  end

  // Set has priority over clear-on-read.
  assign err_d   = err_set | (err_q & ~err_clr);
  assign wrcnt_d = bank_we ? wrcnt_q + 8'd1 : wrcnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        bank_q[w] <= '0;
      end
    end else if (bank_we) begin
      bank_q[word] <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q   <= 1'b0;
      wrcnt_q <= '0;
    end else begin
      err_q   <= err_d;
      wrcnt_q <= wrcnt_d;
    end
  end

`ifdef AVALON_IO_RESPONDER_WAIT_STATE_EN
  ws_state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    waitrequest = 1'b0;
    unique case (state_q)
      IDLE: begin
        waitrequest = cmd;
        if (cmd) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`else
  assign waitrequest = 1'b0;
`endif

  avalon_io_rd_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .rsp_i   (rsp_d),
    .rsp_o   (rsp_q)
  );

  assign avs.waitrequest   = waitrequest;
  assign avs.readdata      = rsp_q.data;
  assign avs.endofpacket   = rsp_q.eop;
  assign avs.readdatavalid = rsp_q.valid;
  assign ctrl_out          = bank_q[CTRL_WORD];

endmodule

// File: tb/tb_avalon_io_responder.sv
// Directed bench for avalon_io_responder: expected reads are queued at issue
// and matched against readdatavalid pulses by a response collector.
module tb_avalon_io_responder;

  localparam int RL = 2;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          p;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ctrl_out;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  exp_t        col_e;

  avalon_io_responder_if bus_if();

  avalon_io_responder #(
    .NUM_WORDS    (48),
    .READ_LATENCY (RL),
    .OOR_DATA     (32'hDEADBEEF)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus_if),
    .ctrl_out (ctrl_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic cmd(input logic r, input logic w, input logic [7:0] a,
                     input logic [3:0] be, input logic [31:0] d,
                     input logic [31:0] xd, input logic xe);
    int   n;
    exp_t e;
    bus_if.read = r;
    bus_if.write = w;
    bus_if.address = a;
    bus_if.byteenable = be;
    bus_if.writedata = d;
    n = 0;
    #1;
    while (bus_if.waitrequest && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus_if.waitrequest) chk("wait_bound", bus_if.waitrequest, 1'b0);
    if (r && !w) begin
      e.d = xd;
      e.e = xe;
      e.p = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus_if.read = 1'b0;
    bus_if.write = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    cmd(1'b0, 1'b1, a, be, d, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] xd, input logic xe);
    cmd(1'b1, 1'b0, a, 4'h0, 32'h0, xd, xe);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_bound", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus_if.readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rdv", 32'd1, 32'd0);
      end else begin
        col_e = exp_q.pop_front();
        chk("rdata", bus_if.readdata, col_e.d);
        chk("eop", 32'(bus_if.endofpacket), 32'(col_e.e));
        chk("rd_latency", 32'(cyc - col_e.p), 32'(RL));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.read = 1'b0;
    bus_if.write = 1'b0;
    bus_if.address = '0;
    bus_if.byteenable = '0;
    bus_if.writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdv", 32'(bus_if.readdatavalid), 32'd0);
    chk("rst_rdata", bus_if.readdata, 32'h0);
    chk("rst_eop", 32'(bus_if.endofpacket), 32'd0);
    chk("rst_ctrl", ctrl_out, 32'h0);
    chk("rst_wait", 32'(bus_if.waitrequest), 32'd0);
    reset_n = 1'b1;

    // Byte-lane write then immediate read-back.
    wr(8'h08, 4'b0101, 32'h11223344);
    rd(8'h08, 32'h00220044, 1'b0);
    wr(8'h00, 4'hF, 32'hA5A5A5A5);
    chk("ctrl_out", ctrl_out, 32'hA5A5A5A5);
    rd(8'h04, 32'h00000200, 1'b0);
    rd(8'h00, 32'hA5A5A5A5, 1'b0);

    // Back-to-back reads, last word carries endofpacket.
    wr(8'h0C, 4'hF, 32'hCAFEF00D);
    wr(8'hBC, 4'hF, 32'h47474747);
    rd(8'h08, 32'h00220044, 1'b0);
    rd(8'h0C, 32'hCAFEF00D, 1'b0);
    rd(8'hBC, 32'h47474747, 1'b1);
    wait_idle();
    chk("hold_rdv", 32'(bus_if.readdatavalid), 32'd0);
    chk("hold_rdata", bus_if.readdata, 32'h47474747);
    chk("hold_eop", 32'(bus_if.endofpacket), 32'd1);

    // Status word is read-only and not counted.
    wr(8'h04, 4'hF, 32'hFFFFFFFF);
    rd(8'h04, 32'h00000400, 1'b0);

    // Out-of-range read, sticky error, clear-on-read.
    rd(8'hC0, 32'hDEADBEEF, 1'b0);
    rd(8'h04, 32'h00000401, 1'b0);
    rd(8'h04, 32'h00000400, 1'b0);
    wr(8'hC8, 4'hF, 32'h12345678);
    rd(8'h04, 32'h00000401, 1'b0);
    wr(8'hC8, 4'hF, 32'h12345678);
    rd(8'h04, 32'h00000401, 1'b0);
    rd(8'h04, 32'h00000400, 1'b0);

    // Read and write together: write wins, no response.
    cmd(1'b1, 1'b1, 8'h0C, 4'b0011, 32'h0000BEEF, 32'h0, 1'b0);
    rd(8'h0C, 32'hCAFEBEEF, 1'b0);
    rd(8'h04, 32'h00000500, 1'b0);

    // Write counter wrap: 6 -> 256 == 0.
    wr(8'h14, 4'b1000, 32'hAABBCCDD);
    for (int i = 0; i < 250; i++) wr(8'h14, 4'b1000, 32'hAABBCCDD);
    rd(8'h14, 32'hAA000000, 1'b0);
    rd(8'h04, 32'h00000000, 1'b0);
    chk("ctrl_keep", ctrl_out, 32'hA5A5A5A5);
    wait_idle();

    // Reset while reads are in flight.
    bus_if.read = 1'b1;
    bus_if.address = 8'h08;
    @(negedge clk);
    bus_if.address = 8'h0C;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    bus_if.read = 1'b0;
    #1;
    chk("midrst_rdv", 32'(bus_if.readdatavalid), 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_ctrl", ctrl_out, 32'h0);
    chk("midrst_rdata", bus_if.readdata, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_rdv", 32'(bus_if.readdatavalid), 32'd0);
    end
    rd(8'h08, 32'h00000000, 1'b0);
    rd(8'h04, 32'h00000000, 1'b0);
    wait_idle();

`ifdef AVALON_IO_RESPONDER_WAIT_STATE_EN
    bus_if.write = 1'b1;
    bus_if.address = 8'h10;
    bus_if.byteenable = 4'hF;
    bus_if.writedata = 32'h1;
    #1;
    chk("ws_idle_wait", 32'(bus_if.waitrequest), 32'd1);
    @(negedge clk);
    #1;
    chk("ws_ack_wait", 32'(bus_if.waitrequest), 32'd0);
    @(negedge clk);
    bus_if.write = 1'b0;
    #1;
    chk("ws_idle_quiet", 32'(bus_if.waitrequest), 32'd0);
`else
    bus_if.write = 1'b1;
    bus_if.address = 8'h10;
    bus_if.byteenable = 4'hF;
    bus_if.writedata = 32'h1;
    #1;
    chk("wait_zero", 32'(bus_if.waitrequest), 32'd0);
    @(negedge clk);
    bus_if.write = 1'b0;
`endif
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
